// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths, FSM states and strip-width helper for the tile scheduler
package systolic_pkg;

  localparam int DEF_SYSTOLIC_SIZE = 16;

  localparam int OFM_W  = 9;
  localparam int NF_W   = 11;
  localparam int KS_W   = 2;
  localparam int CMP_W  = 12;
  localparam int GRP_W  = 7;
  localparam int COLS_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_FETCH,
    ST_COMPUTE,
    ST_WAIT_COMP,
    ST_ADVANCE,
    ST_DONE
  } sched_state_e;

  // Columns covered by a strip: the array width, or whatever is left of the map.
  function automatic logic [COLS_W-1:0] strip_cols(input logic [CMP_W-1:0] remaining,
                                                   input logic [CMP_W-1:0] ss);
    logic [CMP_W-1:0] m;
    m = (remaining >= ss) ? ss : remaining;
    return COLS_W'(m);
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// rtl/conv_tile_scheduler_if.sv - load/done handshake between scheduler and fetch/compute datapath
interface conv_tile_scheduler_if;

  logic ifm_load;
  logic wgt_load;
  logic ifm_done;
  logic wgt_done;
  logic compute_start;
  logic compute_done;

  modport master (
    output ifm_load, wgt_load, compute_start,
    input  ifm_done, wgt_done, compute_done
  );

  modport slave (
    input  ifm_load, wgt_load, compute_start,
    output ifm_done, wgt_done, compute_done
  );

endinterface

// File: rtl/conv_tile_scheduler_tile_counter.sv
// rtl/conv_tile_scheduler_tile_counter.sv - nested row/strip/filter-group counter
// Row is innermost, then column strip, then filter group; last_tile flags the final tile.
module sched_tile_counter
  import systolic_pkg::*;
#(
  parameter int SS = DEF_SYSTOLIC_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [OFM_W-1:0]  ofm_size,
  input  logic [NF_W-1:0]   num_filter,
  output logic [OFM_W-1:0]  row,
  output logic [OFM_W-1:0]  col_base,
  output logic [COLS_W-1:0] cols,
  output logic [GRP_W-1:0]  group,
  output logic              first_of_group,
  output logic              last_tile
);

  localparam logic [CMP_W-1:0] SS_C = CMP_W'(SS);

  logic [OFM_W-1:0]  row_q, row_d;
  logic [OFM_W-1:0]  col_q, col_d;
  logic [COLS_W-1:0] cols_q, cols_d;
  logic [GRP_W-1:0]  grp_q, grp_d;

  logic [CMP_W-1:0] ofm_c, row_nxt, col_nxt, grp_end;
  logic             row_last, col_last, grp_last;

  assign ofm_c    = CMP_W'(ofm_size);
  assign row_nxt  = CMP_W'(row_q) + CMP_W'(1);
  assign col_nxt  = CMP_W'(col_q) + SS_C;
  assign grp_end  = (CMP_W'(grp_q) + CMP_W'(1)) * SS_C;
  assign row_last = row_nxt >= ofm_c;
  assign col_last = col_nxt >= ofm_c;
  assign grp_last = grp_end >= CMP_W'(num_filter);

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    cols_d = cols_q;
    grp_d  = grp_q;
    if (clear) begin
      row_d  = '0;
      col_d  = '0;
      grp_d  = '0;
      cols_d = strip_cols(ofm_c, SS_C);
    end else if (advance) begin
      if (!row_last) begin
        row_d = OFM_W'(row_nxt);
      end else begin
        row_d = '0;
        if (col_last) begin
          col_d  = '0;
          cols_d = strip_cols(ofm_c, SS_C);
          grp_d  = grp_q + GRP_W'(1);
        end else begin
          col_d  = OFM_W'(col_nxt);
          cols_d = strip_cols(ofm_c - col_nxt, SS_C);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      cols_q <= '0;
      grp_q  <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      cols_q <= cols_d;
      grp_q  <= grp_d;
    end
  end

  assign row            = row_q;
  assign col_base       = col_q;
  assign cols           = cols_q;
  assign group          = grp_q;
  assign first_of_group = (row_q == '0) && (col_q == '0);
  assign last_tile      = row_last && col_last && grp_last;

endmodule

// File: rtl/conv_tile_scheduler.sv
// rtl/conv_tile_scheduler.sv - per-layer tile sequencer driving IFM/weight fetch and the systolic array
// Optional SCHED_PERF_CNT_EN adds stall_cycles/busy_cycles counters.
module conv_tile_scheduler
  import systolic_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [OFM_W-1:0]      cfg_ofm_size,
  input  logic [NF_W-1:0]       cfg_num_filter,
  input  logic [KS_W-1:0]       cfg_kernel_size,
  conv_tile_scheduler_if.master dp,
  output logic [OFM_W-1:0]      tile_row,
  output logic [OFM_W-1:0]      tile_col_base,
  output logic [COLS_W-1:0]     tile_cols,
  output logic [GRP_W-1:0]      filter_group,
  output logic                  busy,
  output logic                  layer_done
`ifdef SCHED_PERF_CNT_EN
 ,output logic [31:0]           stall_cycles,
  output logic [31:0]           busy_cycles
`endif
);

  sched_state_e state_q, state_d;
  logic [OFM_W-1:0] ofm_q, ofm_d;
  logic [NF_W-1:0]  nf_q, nf_d;
  logic [KS_W-1:0]  ks_q, ks_d;
  logic             busy_q, busy_d;
  logic             ifm_flag_q, ifm_flag_d;
  logic             wgt_flag_q, wgt_flag_d;

  logic             accept, advance;
  logic             first_of_group, last_tile;
  logic [OFM_W-1:0] cnt_ofm;

  // Kernel size only shapes the address generators' walk; it is held with the layer config.
  logic ks_unused;
  assign ks_unused = ^ks_q;

  // The counter is cleared in the same cycle the config is latched, so feed it the live value.
  assign cnt_ofm = (state_q == ST_IDLE) ? cfg_ofm_size : ofm_q;

  sched_tile_counter #(.SS(SYSTOLIC_SIZE)) u_tile_counter (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (accept),
    .advance        (advance),
    .ofm_size       (cnt_ofm),
    .num_filter     (nf_q),
    .row            (tile_row),
    .col_base       (tile_col_base),
    .cols           (tile_cols),
    .group          (filter_group),
    .first_of_group (first_of_group),
    .last_tile      (last_tile)
  );

  always_comb begin
    state_d          = state_q;
    ofm_d            = ofm_q;
    nf_d             = nf_q;
    ks_d             = ks_q;
    busy_d           = busy_q;
    ifm_flag_d       = ifm_flag_q;
    wgt_flag_d       = wgt_flag_q;
    accept           = 1'b0;
    advance          = 1'b0;
    dp.ifm_load      = 1'b0;
    dp.wgt_load      = 1'b0;
    dp.compute_start = 1'b0;
    layer_done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          ofm_d   = cfg_ofm_size;
          nf_d    = cfg_num_filter;
          ks_d    = cfg_kernel_size;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dp.ifm_load = 1'b1;
        dp.wgt_load = first_of_group;
        ifm_flag_d  = 1'b0;
        wgt_flag_d  = !first_of_group;
        state_d     = ST_WAIT_FETCH;
      end
      ST_WAIT_FETCH: begin
        ifm_flag_d = ifm_flag_q | dp.ifm_done;
        wgt_flag_d = wgt_flag_q | dp.wgt_done;
        if (ifm_flag_d && wgt_flag_d) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        dp.compute_start = 1'b1;
        state_d          = ST_WAIT_COMP;
      end
      ST_WAIT_COMP: begin
        if (dp.compute_done) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        // The final tile is not stepped past, so tile outputs keep its coordinates.
        if (last_tile) begin
          state_d = ST_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        layer_done = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ofm_q      <= '0;
      nf_q       <= '0;
      ks_q       <= '0;
      busy_q     <= 1'b0;
      ifm_flag_q <= 1'b0;
      wgt_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ofm_q      <= ofm_d;
      nf_q       <= nf_d;
      ks_q       <= ks_d;
      busy_q     <= busy_d;
      ifm_flag_q <= ifm_flag_d;
      wgt_flag_q <= wgt_flag_d;
    end
  end

  assign busy = busy_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] busyc_q, busyc_d;

  always_comb begin
    stall_d = stall_q;
    busyc_d = busyc_q;
    if (accept) begin
      stall_d = '0;
      busyc_d = '0;
    end else begin
      if ((state_q == ST_WAIT_FETCH) && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (busy_q && (busyc_q != '1)) busyc_d = busyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      busyc_q <= '0;
    end else begin
      stall_q <= stall_d;
      busyc_q <= busyc_d;
    end
  end

  assign stall_cycles = stall_q;
  assign busy_cycles  = busyc_q;
`endif

endmodule
